// File: rtl/uart_rx_axis.sv
// Oversampling UART receiver with majority-vote sampling,
// configurable framing and a small AXI-Stream output FIFO.
module uart_rx_axis #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic                 m_axis_tuser,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_W   = $clog2(OVERSAMPLE);
    localparam int B_W   = $clog2(DATA_BITS);
    localparam int M     = OVERSAMPLE / 2;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int FW    = DATA_BITS + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0]   S_ONE    = S_W'(1);
    localparam logic [S_W-1:0]   S_V0     = S_W'(M - 1);
    localparam logic [S_W-1:0]   S_V1     = S_W'(M);
    localparam logic [S_W-1:0]   S_V2     = S_W'(M + 1);
    localparam logic [B_W-1:0]   B_LAST   = B_W'(DATA_BITS - 1);
    localparam logic [B_W-1:0]   B_ONE    = B_W'(1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [AW:0]      PTR_ONE  = (AW + 1)'(1);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_axis: CLK_FREQ too low for BAUD*OVERSAMPLE");
    end

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP
    } state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [S_W-1:0]       s_q, s_d;
    logic [B_W-1:0]       bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic                 v0_q, v0_d, v1_q, v1_d;
    logic                 armed_q, armed_d;
    logic                 perr_q, perr_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [FW-1:0]        mem_q [FIFO_DEPTH];
    logic [FW-1:0]        mem_d [FIFO_DEPTH];
    logic [AW:0]          wr_q, wr_d, rd_q, rd_d;

    logic rx_s, tick, vote_now, vote, bit_end, push;
    logic full, pop, do_push;
    logic [FW-1:0] rd_word;

    assign rx_s     = sync2_q;
    assign tick     = (div_q == DIV_LAST);
    assign vote_now = tick && (s_q == S_V2);
    assign bit_end  = tick && (s_q == S_LAST);
    assign vote     = (v0_q & v1_q) | (v0_q & rx_s) | (v1_q & rx_s);

    always_comb begin
        sync1_d   = rx;
        sync2_d   = sync1_q;
        div_d     = tick ? '0 : div_q + DIV_ONE;
        s_d       = s_q;
        v0_d      = v0_q;
        v1_d      = v1_q;
        state_d   = state_q;
        armed_d   = armed_q;
        bit_d     = bit_q;
        stop_d    = stop_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        push      = 1'b0;
        frame_err = 1'b0;
        if (tick) s_d = (s_q == S_LAST) ? '0 : s_q + S_ONE;
        if (tick && s_q == S_V0) v0_d = rx_s;
        if (tick && s_q == S_V1) v1_d = rx_s;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_s) armed_d = 1'b1;
                if (armed_q && !rx_s) begin
                    state_d = ST_START;
                    s_d     = '0;
                    div_d   = '0;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    perr_d  = 1'b0;
                end
            end
            ST_START: begin
                if (vote_now && vote) state_d = ST_IDLE;
                else if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (vote_now) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_q == B_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_d = bit_q + B_ONE;
                    end
                end
            end
            ST_PAR: begin
                // perr set when the total ones count breaks the mode's rule
                if (vote_now)
                    perr_d = (PARITY == 1) ? ~(^shift_q ^ vote)
                                           : (^shift_q ^ vote);
                if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (vote_now && !vote) begin
                    frame_err = 1'b1;
                    armed_d   = 1'b0;
                    state_d   = ST_IDLE;
                end else if (vote_now && stop_q == STOP_LAST) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    stop_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = m_axis_tvalid && m_axis_tready;
    assign do_push = push && (!full || pop);
    assign rd_word = mem_q[rd_q[AW-1:0]];

    assign m_axis_tvalid = (wr_q != rd_q);
    assign m_axis_tdata  = rd_word[DATA_BITS-1:0];
    assign m_axis_tuser  = rd_word[DATA_BITS];
    assign parity_err    = push && perr_q;
    assign overrun       = push && full && !pop;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = {perr_q, shift_q};
            wr_d = wr_q + PTR_ONE;
        end
        if (pop) rd_d = rd_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            div_q   <= '0;
            s_q     <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            v0_q    <= 1'b1;
            v1_q    <= 1'b1;
            armed_q <= 1'b1;
            perr_q  <= 1'b0;
            shift_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            div_q   <= div_d;
            s_q     <= s_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            armed_q <= armed_d;
            perr_q  <= perr_d;
            shift_q <= shift_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_axis.sv
// Bench for uart_rx_axis: an 8N1 instance and an 8E1 instance
// driven with serial frames and checked against a frame-level model.
module tb_uart_rx_axis;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int OS       = 16;
    localparam int BIT_CLK  = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_n, rx_e, tr_n, tr_e;
    logic [7:0] td_n, td_e;
    logic tu_n, tu_e, tv_n, tv_e;
    logic fe_n, pe_n, ov_n, fe_e, pe_e, ov_e;

    int ntest, nfail;
    logic [8:0] obs_n[$], obs_e[$], exp_n[$], exp_e[$];
    int rise[2][3];
    int high[2][3];
    logic [2:0] prev_n, prev_e;

    always #5 clk = ~clk;

    uart_rx_axis #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
        .STOP_BITS(1), .OVERSAMPLE(OS), .FIFO_DEPTH(4)
    ) u_n (
        .clk(clk), .rst_n(rst_n), .rx(rx_n),
        .m_axis_tdata(td_n), .m_axis_tuser(tu_n), .m_axis_tvalid(tv_n),
        .m_axis_tready(tr_n), .frame_err(fe_n), .parity_err(pe_n),
        .overrun(ov_n)
    );

    uart_rx_axis #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
        .STOP_BITS(1), .OVERSAMPLE(OS), .FIFO_DEPTH(4)
    ) u_e (
        .clk(clk), .rst_n(rst_n), .rx(rx_e),
        .m_axis_tdata(td_e), .m_axis_tuser(tu_e), .m_axis_tvalid(tv_e),
        .m_axis_tready(tr_e), .frame_err(fe_e), .parity_err(pe_e),
        .overrun(ov_e)
    );

    // flag index: 0 frame_err, 1 parity_err, 2 overrun
    always @(negedge clk) begin
        if (rst_n) begin
            if (tv_n && tr_n) obs_n.push_back({tu_n, td_n});
            if (tv_e && tr_e) obs_e.push_back({tu_e, td_e});
            for (int k = 0; k < 3; k++) begin
                if ({ov_n, pe_n, fe_n}[k]) begin
                    high[0][k]++;
                    if (!prev_n[k]) rise[0][k]++;
                end
                if ({ov_e, pe_e, fe_e}[k]) begin
                    high[1][k]++;
                    if (!prev_e[k]) rise[1][k]++;
                end
            end
            prev_n = {ov_n, pe_n, fe_n};
            prev_e = {ov_e, pe_e, fe_e};
        end
    end

    function automatic logic [8:0] model(input logic [7:0] d,
                                         input bit even_par,
                                         input bit pbit);
        bit perr;
        perr = even_par && ((($countones(d) + int'(pbit)) % 2) != 0);
        return {perr, d};
    endfunction

    task automatic clear_mon();
        obs_n.delete(); obs_e.delete(); exp_n.delete(); exp_e.delete();
        for (int w = 0; w < 2; w++)
            for (int k = 0; k < 3; k++) begin
                rise[w][k] = 0;
                high[w][k] = 0;
            end
    endtask

    task automatic set_ready(input int w, input bit v);
        @(posedge clk);
        #1;
        if (w == 0) tr_n = v; else tr_e = v;
    endtask

    task automatic drive(input int w, input bit v);
        if (w == 0) rx_n = v; else rx_e = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input int w, input logic [7:0] d,
                              input bit has_par, input bit pbit,
                              input bit stop_v);
        drive(w, 1'b0);
        for (int i = 0; i < 8; i++) drive(w, d[i]);
        if (has_par) drive(w, pbit);
        drive(w, stop_v);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        ntest++;
        if ({tv_n, tu_n, td_n} !== 10'd0) begin
            nfail++;
            $display("FAIL reset_out_n: got %h exp 0", {tv_n, tu_n, td_n});
        end
        ntest++;
        if ({fe_n, pe_n, ov_n} !== 3'b0) begin
            nfail++;
            $display("FAIL reset_flags_n: got %b exp 000", {fe_n, pe_n, ov_n});
        end
        ntest++;
        if ({tv_e, tu_e, td_e, fe_e, pe_e, ov_e} !== 13'd0) begin
            nfail++;
            $display("FAIL reset_out_e: got %h exp 0",
                     {tv_e, tu_e, td_e, fe_e, pe_e, ov_e});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        ntest++;
        if (tv_n !== 1'b0) begin
            nfail++;
            $display("FAIL reset_idle_tvalid: got %b exp 0", tv_n);
        end
    endtask

    task automatic test_clean();
        logic [7:0] d;
        clear_mon();
        set_ready(0, 1'b1);
        repeat (2) @(negedge clk);
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        exp_n.push_back(model(8'hA5, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            send_frame(0, d, 1'b0, 1'b0, 1'b1);
            exp_n.push_back(model(d, 1'b0, 1'b0));
        end
        repeat (6) @(negedge clk);
        ntest++;
        if (obs_n.size() != exp_n.size()) begin
            nfail++;
            $display("FAIL clean_count: got %0d exp %0d",
                     obs_n.size(), exp_n.size());
        end
        for (int i = 0; i < exp_n.size() && i < obs_n.size(); i++) begin
            ntest++;
            if (obs_n[i] !== exp_n[i]) begin
                nfail++;
                $display("FAIL clean_word%0d: got %h exp %h",
                         i, obs_n[i], exp_n[i]);
            end
        end
        ntest++;
        if (rise[0][0] + rise[0][1] + rise[0][2] != 0) begin
            nfail++;
            $display("FAIL clean_flags: got %0d pulses exp 0",
                     rise[0][0] + rise[0][1] + rise[0][2]);
        end
    endtask

    task automatic test_parity();
        logic [7:0] d;
        bit pb;
        int nbad;
        clear_mon();
        nbad = 1;
        set_ready(1, 1'b1);
        send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1);
        exp_e.push_back(model(8'h3C, 1'b1, 1'b1));
        repeat (4) @(negedge clk);
        ntest++;
        if (rise[1][1] != 1 || high[1][1] != 1) begin
            nfail++;
            $display("FAIL parity_pulse: got rises %0d cycles %0d exp 1 1",
                     rise[1][1], high[1][1]);
        end
        send_frame(1, 8'h3C, 1'b1, 1'b0, 1'b1);
        exp_e.push_back(model(8'h3C, 1'b1, 1'b0));
        for (int i = 0; i < 6; i++) begin
            d  = 8'($urandom_range(0, 255));
            pb = 1'($urandom_range(0, 1));
            send_frame(1, d, 1'b1, pb, 1'b1);
            exp_e.push_back(model(d, 1'b1, pb));
            if (model(d, 1'b1, pb) >= 9'h100) nbad++;
        end
        repeat (6) @(negedge clk);
        ntest++;
        if (obs_e.size() != exp_e.size()) begin
            nfail++;
            $display("FAIL parity_count: got %0d exp %0d",
                     obs_e.size(), exp_e.size());
        end
        for (int i = 0; i < exp_e.size() && i < obs_e.size(); i++) begin
            ntest++;
            if (obs_e[i] !== exp_e[i]) begin
                nfail++;
                $display("FAIL parity_word%0d: got %h exp %h",
                         i, obs_e[i], exp_e[i]);
            end
        end
        ntest++;
        if (rise[1][1] != nbad || high[1][1] != nbad) begin
            nfail++;
            $display("FAIL parity_flags: got rises %0d cycles %0d exp %0d",
                     rise[1][1], high[1][1], nbad);
        end
    endtask

    task automatic test_false_start();
        logic [7:0] d;
        clear_mon();
        rx_n = 1'b0;
        repeat (4) @(negedge clk);
        rx_n = 1'b1;
        repeat (60) @(negedge clk);
        ntest++;
        if (obs_n.size() != 0 || tv_n !== 1'b0) begin
            nfail++;
            $display("FAIL false_start_word: got %0d words tvalid %b exp 0 0",
                     obs_n.size(), tv_n);
        end
        ntest++;
        if (rise[0][0] + rise[0][1] + rise[0][2] != 0) begin
            nfail++;
            $display("FAIL false_start_flags: got %0d pulses exp 0",
                     rise[0][0] + rise[0][1] + rise[0][2]);
        end
        d = 8'($urandom_range(0, 255));
        send_frame(0, d, 1'b0, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        ntest++;
        if (obs_n.size() != 1 || obs_n[0] !== model(d, 1'b0, 1'b0)) begin
            nfail++;
            $display("FAIL false_start_next: got %0d words exp 1 of %h",
                     obs_n.size(), model(d, 1'b0, 1'b0));
        end
    endtask

    task automatic test_frame_err();
        clear_mon();
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b1);
        ntest++;
        if (rise[0][0] != 1 || high[0][0] != 1) begin
            nfail++;
            $display("FAIL frame_err_pulse: got rises %0d cycles %0d exp 1 1",
                     rise[0][0], high[0][0]);
        end
        ntest++;
        if (obs_n.size() != 0 || rise[0][1] + rise[0][2] != 0) begin
            nfail++;
            $display("FAIL frame_err_drop: got %0d words %0d flags exp 0 0",
                     obs_n.size(), rise[0][1] + rise[0][2]);
        end
        send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        ntest++;
        if (obs_n.size() != 1 || obs_n[0] !== 9'h012) begin
            nfail++;
            $display("FAIL frame_err_next: got %0d words first %h exp 1 012",
                     obs_n.size(), obs_n.size() > 0 ? obs_n[0] : 9'h1ff);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        clear_mon();
        set_ready(0, 1'b0);
        for (int i = 1; i <= 4; i++)
            send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1);
        ntest++;
        if (rise[0][2] != 0 || tv_n !== 1'b1 || td_n !== 8'h01) begin
            nfail++;
            $display("FAIL bp_full: got ovr %0d tvalid %b tdata %h exp 0 1 01",
                     rise[0][2], tv_n, td_n);
        end
        send_frame(0, 8'h05, 1'b0, 1'b0, 1'b1);
        ntest++;
        if (rise[0][2] != 1 || high[0][2] != 1) begin
            nfail++;
            $display("FAIL bp_overrun: got rises %0d cycles %0d exp 1 1",
                     rise[0][2], high[0][2]);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (tv_n !== 1'b1 || td_n !== 8'h01 || tu_n !== 1'b0) bad++;
        end
        ntest++;
        if (bad != 0) begin
            nfail++;
            $display("FAIL bp_stable: got %0d unstable cycles exp 0", bad);
        end
        set_ready(0, 1'b1);
        repeat (10) @(negedge clk);
        ntest++;
        if (obs_n.size() != 4) begin
            nfail++;
            $display("FAIL bp_drain_count: got %0d exp 4", obs_n.size());
        end
        for (int i = 0; i < 4 && i < obs_n.size(); i++) begin
            ntest++;
            if (obs_n[i] !== 9'(i + 1)) begin
                nfail++;
                $display("FAIL bp_drain%0d: got %h exp %h",
                         i, obs_n[i], 9'(i + 1));
            end
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] d;
        bit pb;
        bit done;
        clear_mon();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    d  = 8'($urandom_range(0, 255));
                    pb = 1'($urandom_range(0, 1));
                    send_frame(1, d, 1'b1, pb, 1'b1);
                    exp_e.push_back(model(d, 1'b1, pb));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 tr_e = 1'($urandom_range(0, 1));
                end
            end
        join
        set_ready(1, 1'b1);
        for (int i = 0; i < 100 && obs_e.size() < exp_e.size(); i++)
            @(negedge clk);
        ntest++;
        if (obs_e.size() != exp_e.size() || rise[1][2] != 0) begin
            nfail++;
            $display("FAIL stream_count: got %0d words %0d ovr exp %0d 0",
                     obs_e.size(), rise[1][2], exp_e.size());
        end
        for (int i = 0; i < exp_e.size() && i < obs_e.size(); i++) begin
            ntest++;
            if (obs_e[i] !== exp_e[i]) begin
                nfail++;
                $display("FAIL stream_word%0d: got %h exp %h",
                         i, obs_e[i], exp_e[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        clear_mon();
        set_ready(0, 1'b0);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        ntest++;
        if (tv_n !== 1'b1) begin
            nfail++;
            $display("FAIL rst_mid_pending: got tvalid %b exp 1", tv_n);
        end
        d = 8'hF8;
        drive(0, 1'b0);
        for (int i = 0; i < 4; i++) drive(0, d[i]);
        rx_n = d[4];
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        ntest++;
        if ({tv_n, tu_n, td_n, fe_n, pe_n, ov_n} !== 13'd0) begin
            nfail++;
            $display("FAIL rst_mid_out: got %h exp 0",
                     {tv_n, tu_n, td_n, fe_n, pe_n, ov_n});
        end
        rst_n = 1'b1;
        repeat (BIT_CLK - 7) @(negedge clk);
        for (int i = 5; i < 8; i++) drive(0, d[i]);
        drive(0, 1'b1);
        clear_mon();
        set_ready(0, 1'b1);
        repeat (40) @(negedge clk);
        ntest++;
        if (obs_n.size() != 0 || rise[0][0] + rise[0][1] != 0) begin
            nfail++;
            $display("FAIL rst_mid_tail: got %0d words %0d flags exp 0 0",
                     obs_n.size(), rise[0][0] + rise[0][1]);
        end
        send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        ntest++;
        if (obs_n.size() != 1 || obs_n[0] !== 9'h0C3) begin
            nfail++;
            $display("FAIL rst_mid_next: got %0d words first %h exp 1 0c3",
                     obs_n.size(), obs_n.size() > 0 ? obs_n[0] : 9'h1ff);
        end
    endtask

    initial begin
        ntest  = 0;
        nfail  = 0;
        rx_n   = 1'b1;
        rx_e   = 1'b1;
        tr_n   = 1'b0;
        tr_e   = 1'b0;
        prev_n = '0;
        prev_e = '0;
        rst_n  = 1'b0;
        clear_mon();
        test_reset();
        test_clean();
        test_parity();
        test_false_start();
        test_frame_err();
        test_back_to_back();
        test_random_stream();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule

// File: doc/uart_rx_axis.md
# uart_rx_axis

Parametrised UART receiver with an AXI-Stream master output. It generalises the fixed 8N1 receiver to:
- configurable word length, parity and stop bits;
- oversampled mid-bit sampling with majority vote;
- false-start rejection;
- error flagging;
- a small output FIFO so a stalled downstream consumer does not lose back-to-back frames.

It sits between the pad-level `rx` line and the AXIS fabric.

## Interface
- `CLK_FREQ`, 100_000_000, clock frequency in Hz
- `BAUD`, 115200, line rate in bit/s
- `DATA_BITS`, 8, data bits per frame, legal range 5..9
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even
- `STOP_BITS`, 1, stop bits per frame: 1 or 2
- `OVERSAMPLE`, 16, sample ticks per bit; even, ≥ 8
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥ 2
- `clk` in 1, system clock; all logic on the rising edge
- `rst_n` in 1, asynchronous active-low reset
- `rx` in 1, asynchronous serial input, idle high
- `m_axis_tdata` out DATA_BITS, received word, LSB first on the line
- `m_axis_tuser` out 1, parity error flag for the word on `tdata`
- `m_axis_tvalid` out 1, FIFO non-empty
- `m_axis_tready` in 1, downstream accept
- `frame_err` out 1, one-cycle pulse: stop bit sampled low
- `parity_err` out 1, one-cycle pulse: parity mismatch
- `overrun` out 1, one-cycle pulse: word dropped because the FIFO was full

## Operation
- **Input synchroniser.** `rx` passes through a 2-flop synchroniser; both flops reset to 1.
- **Tick generator.**
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), truncated; elaboration fails if DIV < 1.
  - Free-running counter 0..DIV-1; `tick` is asserted for one clk at DIV-1.
  - The counter restarts at 0 on the clk a start is detected.
- **Sample counter.** `s` runs 0..OVERSAMPLE-1 per bit and advances on `tick`.
- **Majority vote.** Let M = OVERSAMPLE/2. Samples are taken at s = M-1, M, M+1. The bit value is the majority of the three and is decided at s = M+1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** armed and synchronised `rx` = 0 → START, with `s` = 0 and the tick counter cleared. Armed is set whenever `rx` = 1 has been seen in IDLE.
  - **START:** if the voted value is 1 → IDLE (false start, no flags). Otherwise, at s = OVERSAMPLE-1 → DATA with bit_cnt = 0.
  - **DATA:** the voted bit shifts in at the MSB end (LSB first). At s = OVERSAMPLE-1, after the last data bit → PARITY if PARITY ≠ 0, else STOP.
  - **PARITY:** the voted bit is compared against the XOR of the data. Odd mode requires odd total ones; even mode requires even total ones. The result is held as `perr`. At s = OVERSAMPLE-1 → STOP.
  - **STOP:** each stop bit is voted.
    - Any stop bit voted 0: `frame_err` pulses, the word is discarded, armed clears, → IDLE immediately.
    - Otherwise, at the vote of the final stop bit (mid-bit, not end of bit): push {perr, data}, pulse `parity_err` if perr, → IDLE. This allows the next start edge to be caught with no lost time.
- **FIFO.**
  - Push at frame completion; pop when `tvalid` && `tready`.
  - Full and push without pop: the word is dropped, `overrun` pulses, FIFO contents are unchanged.
  - Full with push and pop in the same clk: both occur, no overrun.
  - Empty with push: the word appears next clk; there is no same-cycle bypass.
- **Data ordering.** Words leave in arrival order. `tdata`/`tuser` are stable while `tvalid` && !`tready`.

## Timing
- **Reset values:**
  - All outputs are 0; `tvalid` = 0; FIFO empty; FSM in IDLE.
  - armed = 1; synchroniser flops = 1.
  - Tick counter, `s` and bit_cnt are 0.
- **Reset mid-frame:** the partial word is lost and no flags are raised.
- **Start detection latency:** 2 clk (synchroniser) from the `rx` falling edge to leaving IDLE.
- **Output latency:** `tvalid` rises 1 clk after the final-stop-bit vote, provided the FIFO was empty.
- **Flag timing:** `parity_err` and `overrun` pulse in the same clk as the push attempt. `frame_err` pulses in the clk of the failing vote.
- **Pulse width:** every flag is exactly 1 clk, even for consecutive frames.
- **Counter widths:** `$clog2` of their range, +1 bit wherever a compare reaches the range value.
- **Frame length:** 1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS bit times of OVERSAMPLE*DIV clk each.

## Test plan
Bench parameters: CLK_FREQ = 1_600_000, BAUD = 100_000, OVERSAMPLE = 16, giving DIV = 1 and 16 clk per bit.
- **Clean frame:** 8N1 frame 0xA5 with `tready` = 1 → one `tvalid` beat, `tdata` = 0xA5, `tuser` = 0, no flags.
- **Parity error:** PARITY = 2, 0x3C sent with parity bit 1 (wrong) → word 0x3C, `tuser` = 1, `parity_err` 1-clk pulse. Repeat with parity bit 0 → `tuser` = 0.
- **False start:** `rx` low for 4 clk then high → no state change past START, no output, no flags.
- **Frame error:** 0x55 with stop bit held low for a full bit, then line high → `frame_err` pulse, no word. A subsequent valid 0x12 is received correctly.
- **Backpressure:** `tready` = 0, five back-to-back frames 0x01..0x05 with FIFO_DEPTH = 4 → `overrun` pulses once, at the fifth frame. Then raising `tready` yields 0x01..0x04 in order.
- **Reset mid-frame:** `rst_n` pulsed low mid-frame during DATA → all outputs 0. After release, the tail of the aborted frame produces no word, and the next full frame 0xC3 is received correctly.
